// File: rtl/range_search_seq_if.sv
// Bus bundle for range_search_seq: search request from the comparator,
// synchronous-read memory port, and the result handed to the consumer.
interface range_search_seq_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          start;
  logic [AW-1:0] start_adr;
  logic [AW-1:0] end_adr;
  logic          same;
  logic [DW-1:0] key;
  logic          mem_rd_en;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          hit;
  logic [AW-1:0] hit_adr;
  logic [AW:0]   hit_cnt;

  modport master (
    output start, start_adr, end_adr, same, key, mem_rdata,
    input  mem_rd_en, mem_adr, busy, done, hit, hit_adr, hit_cnt
  );

  modport slave (
    input  start, start_adr, end_adr, same, key, mem_rdata,
    output mem_rd_en, mem_adr, busy, done, hit, hit_adr, hit_cnt
  );
endinterface

// File: rtl/range_search_seq.sv
// Walks a synchronous-read memory from start_adr to end_adr looking for key.
// Optional macro SCAN_ALL_EN: scan the whole range and count every match.
module range_search_seq #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               reset,
  range_search_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX = {1'b1, {AW{1'b0}}};

  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] cur_q,      cur_d;
  logic [AW-1:0] end_q,      end_d;
  logic [DW-1:0] key_q,      key_d;
  logic          same_q,     same_d;
  logic          pend_q,     pend_d;
  logic [AW-1:0] pend_adr_q, pend_adr_d;
  logic          hit_q,      hit_d;
  logic [AW-1:0] hit_adr_q,  hit_adr_d;
  logic [AW:0]   cnt_q,      cnt_d;
  logic          done_q,     done_d;

  logic match_s;
  logic stop_s;
  logic last_s;

  assign match_s = pend_q && (bus.mem_rdata == key_q);
  // A single-address range (same) is already at its last address on entry.
  assign last_s  = same_q || (cur_q == end_q);

`ifdef SCAN_ALL_EN
  assign stop_s = 1'b0;
`else
  assign stop_s = match_s;
`endif

  // Next-state, scan pointer and result update.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    key_d      = key_q;
    same_d     = same_q;
    pend_d     = 1'b0;
    pend_adr_d = pend_adr_q;
    hit_d      = hit_q;
    hit_adr_d  = hit_adr_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          key_d     = bus.key;
          end_d     = bus.end_adr;
          same_d    = bus.same;
          cur_d     = bus.start_adr;
          hit_d     = 1'b0;
          hit_adr_d = {AW{1'b0}};
          cnt_d     = {(AW+1){1'b0}};
          if (bus.start_adr > bus.end_adr) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SCAN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        pend_d     = 1'b1;
        pend_adr_d = cur_q;
        if (stop_s) begin
          // The read issued this cycle is dropped along with its pending flag.
          state_d = S_FIN;
          pend_d  = 1'b0;
        end else if (last_s) begin
          state_d = S_DRAIN;
        end else begin
          cur_d = cur_q + ADR_ONE;
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (match_s) begin
      hit_d     = 1'b1;
      hit_adr_d = hit_q ? hit_adr_q : pend_adr_q;
`ifdef SCAN_ALL_EN
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
`else
      cnt_d     = CNT_ONE;
`endif
    end else begin
      hit_adr_d = hit_adr_d;
    end
  end

  assign done_d = (state_d == S_FIN);

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_q      <= {AW{1'b0}};
      end_q      <= {AW{1'b0}};
      key_q      <= {DW{1'b0}};
      same_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_adr_q <= {AW{1'b0}};
      hit_q      <= 1'b0;
      hit_adr_q  <= {AW{1'b0}};
      cnt_q      <= {(AW+1){1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      key_q      <= key_d;
      same_q     <= same_d;
      pend_q     <= pend_d;
      pend_adr_q <= pend_adr_d;
      hit_q      <= hit_d;
      hit_adr_q  <= hit_adr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_rd_en = (state_q == S_SCAN);
  assign bus.busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign bus.mem_adr   = cur_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_adr   = hit_adr_q;
  assign bus.hit_cnt   = cnt_q;

endmodule

// File: tb/tb_range_search_seq.sv
// Randomized and directed bench for range_search_seq against a range-walk reference model.
module tb_range_search_seq;
  logic clk;
  logic reset;
  int   checks_cnt = 0;
  int   errors_cnt = 0;
  logic [7:0] mem [32];

  range_search_seq_if #(.AW(5), .DW(8)) bus ();

  range_search_seq #(.AW(5), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_adr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic run_op(input logic [4:0] s, input logic [4:0] e, input logic [7:0] k, input bit inject);
    int first, nm, n, exp_done, exp_reads, cyc, got_done;
    logic exp_hit;
    logic [4:0] exp_hadr;
    logic [5:0] exp_cnt;
    logic [4:0] rd_q[$];
    bit busy_ok, seq_ok;

    first = -1;
    nm = 0;
    n = (s <= e) ? (int'(e) - int'(s) + 1) : 0;
    for (int a = int'(s); a <= int'(e); a++) begin
      if (mem[a] == k) begin
        if (first < 0) first = a - int'(s);
        nm++;
      end
    end
    exp_hit  = (first >= 0);
    exp_hadr = (first >= 0) ? 5'(int'(s) + first) : 5'd0;
    if (n == 0) begin
      exp_done = 1; exp_reads = 0; exp_cnt = 6'd0;
    end else begin
`ifdef SCAN_ALL_EN
      exp_done = n + 2; exp_reads = n; exp_cnt = 6'(nm);
`else
      if (first < 0) begin
        exp_done = n + 2; exp_reads = n; exp_cnt = 6'd0;
      end else begin
        exp_done = first + 3;
        exp_reads = (first + 2 < n) ? first + 2 : n;
        exp_cnt = 6'd1;
      end
`endif
    end

    @(negedge clk);
    bus.start = 1'b1; bus.start_adr = s; bus.end_adr = e; bus.same = (s == e); bus.key = k;
    @(negedge clk);
    bus.start = 1'b0; bus.start_adr = 5'($urandom); bus.end_adr = 5'($urandom); bus.key = ~k;
    cyc = 1; got_done = 0; busy_ok = 1'b1;
    while (cyc <= 60 && got_done == 0) begin
      if (bus.mem_rd_en) rd_q.push_back(bus.mem_adr);
      if (bus.done) begin
        got_done = cyc;
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        if (inject) begin
          bus.start = 1'b1; bus.start_adr = 5'd0; bus.end_adr = 5'd31; bus.key = k;
        end
      end else begin
        if (!bus.busy) busy_ok = 1'b0;
        if (inject && cyc == 2) begin
          bus.start = 1'b1; bus.start_adr = 5'd0; bus.end_adr = 5'd31; bus.key = k;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_cycle", 32'(got_done), 32'(exp_done));
    chk("busy_during", 32'(busy_ok), 32'd1);

    @(negedge clk);
    bus.start = 1'b0;
    chk("done_single", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_rd_en", 32'(bus.mem_rd_en), 32'd0);

    seq_ok = 1'b1;
    foreach (rd_q[i]) if (rd_q[i] != 5'(int'(s) + i)) seq_ok = 1'b0;
    chk("read_count", 32'(rd_q.size()), 32'(exp_reads));
    chk("read_seq", 32'(seq_ok), 32'd1);
    chk("hit", 32'(bus.hit), 32'(exp_hit));
    chk("hit_adr", 32'(bus.hit_adr), 32'(exp_hadr));
    chk("hit_cnt", 32'(bus.hit_cnt), 32'(exp_cnt));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    chk({tag, "_mem_adr"}, 32'(bus.mem_adr), 32'd0);
    chk({tag, "_hit"}, 32'(bus.hit), 32'd0);
    chk({tag, "_hit_adr"}, 32'(bus.hit_adr), 32'd0);
    chk({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.start_adr = 5'd0; bus.end_adr = 5'd0; bus.same = 1'b0; bus.key = 8'd0;
    fill_mem(8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // Directed scenarios
    run_op(5'd0, 5'd31, 8'h5A, 1'b0);
    mem[7] = 8'h5A; mem[12] = 8'h5A;
    run_op(5'd3, 5'd20, 8'h5A, 1'b0);
    fill_mem(8'h00); mem[31] = 8'hC3;
    run_op(5'd31, 5'd31, 8'hC3, 1'b0);
    run_op(5'd9, 5'd4, 8'h00, 1'b0);
    mem[7] = 8'h5A; mem[12] = 8'h5A;
    run_op(5'd3, 5'd20, 8'h5A, 1'b1);
    run_op(5'd0, 5'd31, 8'hEE, 1'b1);

    // Reset in the middle of a full-range scan
    fill_mem(8'h00);
    @(negedge clk);
    bus.start = 1'b1; bus.start_adr = 5'd0; bus.end_adr = 5'd31; bus.same = 1'b0; bus.key = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("mid_reset");
    @(negedge clk);
    chk("mid_reset_no_done", 32'(bus.done), 32'd0);
    mem[5] = 8'h5A;
    run_op(5'd2, 5'd9, 8'h5A, 1'b0);

    // Randomized operations over a small value alphabet so hits are common
    for (int t = 0; t < 40; t++) begin
      logic [4:0] s, e;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 15));
      s = 5'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(int'(s), 31));
      run_op(s, e, 8'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
